// File: rtl/term_writer.sv
// Character terminal writer: turns an ASCII byte stream into fill/copy requests for a display cell buffer.
// Optional form-feed screen clear is built only when TERM_FORMFEED_EN is defined.
module term_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 25
) (
  input  logic        clk100,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic [10:0] cursor,
  output logic        wr_start,
  output logic [10:0] wr_begin,
  output logic [10:0] wr_end,
  output logic [7:0]  wr_data,
  output logic [7:0]  wr_offset,
  input  logic        wr_complete
);

  typedef enum logic [2:0] {
    IDLE, PUT, SCROLL_COPY, SCROLL_CLEAR, CLEAR_ALL, WAIT
  } state_t;

  localparam logic [10:0] COLS_A      = 11'(COLS);
  localparam logic [10:0] LAST_COL    = 11'(COLS - 1);
  localparam logic [10:0] LAST_ROW    = 11'(ROWS - 1);
  localparam logic [10:0] SCROLL_BASE = 11'((ROWS - 1) * COLS);
  localparam logic [10:0] SCREEN_END  = 11'(ROWS * COLS);
  localparam logic [7:0]  COPY_DIST   = 8'(COLS);
  // A one-row screen has nothing to copy, so the scroll starts with the clear.
  localparam state_t SCROLL_FIRST = (ROWS > 1) ? SCROLL_COPY : SCROLL_CLEAR;

  state_t      state, state_n, ret, ret_n, req;
  logic [10:0] row, row_n, col, col_n, row_base, row_base_n, pos;
  logic [7:0]  data_q, data_n;
  logic        printable;

  assign pos       = row_base + col;
  assign printable = (rx_data >= 8'h20) && (rx_data <= 8'h7E);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      state    <= IDLE;
      ret      <= IDLE;
      row      <= '0;
      col      <= '0;
      row_base <= '0;
      data_q   <= '0;
    end else begin
      state    <= state_n;
      ret      <= ret_n;
      row      <= row_n;
      col      <= col_n;
      row_base <= row_base_n;
      data_q   <= data_n;
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_n    = state;
    ret_n      = ret;
    row_n      = row;
    col_n      = col;
    row_base_n = row_base;
    data_n     = data_q;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          data_n = rx_data;
          if (printable) begin
            state_n = PUT;
          end else if (rx_data == 8'h0D) begin
            col_n = '0;
          end else if (rx_data == 8'h0A) begin
            if (row == LAST_ROW) begin
              state_n = SCROLL_FIRST;
            end else begin
              row_n      = row + 11'd1;
              row_base_n = row_base + COLS_A;
            end
          end else if (rx_data == 8'h08) begin
            if (col != '0) col_n = col - 11'd1;
`ifdef TERM_FORMFEED_EN
          end else if (rx_data == 8'h0C) begin
            state_n = CLEAR_ALL;
`endif
          end
        end
      end
      PUT, SCROLL_COPY, SCROLL_CLEAR, CLEAR_ALL: begin
        ret_n   = state;
        state_n = WAIT;
      end
      WAIT: begin
        if (wr_complete) begin
          state_n = IDLE;
          case (ret)
            PUT: begin
              if (col == LAST_COL) begin
                col_n = '0;
                if (row == LAST_ROW) begin
                  state_n = SCROLL_FIRST;
                end else begin
                  row_n      = row + 11'd1;
                  row_base_n = row_base + COLS_A;
                end
              end else begin
                col_n = col + 11'd1;
              end
            end
            SCROLL_COPY: state_n = SCROLL_CLEAR;
`ifdef TERM_FORMFEED_EN
            CLEAR_ALL: begin
              row_n      = '0;
              col_n      = '0;
              row_base_n = '0;
            end
`endif
            default: state_n = IDLE;
          endcase
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Request fields derive from the request in flight, so they hold steady through WAIT.
  always_comb begin
    req       = (state == WAIT) ? ret : state;
    rx_ready  = 1'b0;
    cursor    = '0;
    wr_start  = 1'b0;
    wr_begin  = '0;
    wr_end    = '0;
    wr_data   = '0;
    wr_offset = '0;
    if (rst_n) begin
      rx_ready = (state == IDLE);
      cursor   = pos;
      wr_start = (state != IDLE) && (state != WAIT);
      case (req)
        PUT: begin
          wr_begin = pos;
          wr_end   = pos + 11'd1;
          wr_data  = data_q;
        end
        SCROLL_COPY: begin
          wr_end    = SCROLL_BASE;
          wr_offset = COPY_DIST;
        end
        SCROLL_CLEAR: begin
          wr_begin = SCROLL_BASE;
          wr_end   = SCREEN_END;
          wr_data  = 8'h20;
        end
`ifdef TERM_FORMFEED_EN
        CLEAR_ALL: begin
          wr_end  = SCREEN_END;
          wr_data = 8'h20;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/term_writer.md
TERM_WRITER -- requirements
Module: term_writer

Interface
REQ-001 Parameter COLS, default 80, characters per row.
REQ-002 Parameter ROWS, default 25, rows per screen; COLS*ROWS SHALL be at most 2047.
REQ-003 clk100  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 rx_valid  in  1  input byte available.
REQ-006 rx_data  in  8  input byte (ASCII).
REQ-007 rx_ready  out  1  block accepts rx_data this cycle.
REQ-008 cursor  out  11  current cell index, row*COLS+col.
REQ-009 wr_start  out  1  one-cycle request pulse to the display write port.
REQ-010 wr_begin  out  11  first cell of the request.
REQ-011 wr_end  out  11  one past the last cell of the request.
REQ-012 wr_data  out  8  fill byte, used when wr_offset is 0.
REQ-013 wr_offset  out  8  copy source distance; nonzero means cell[a] <= cell[a+wr_offset].
REQ-014 wr_complete  in  1  one-cycle pulse from the display when a request finishes.

Function
REQ-015 Internal row (0..ROWS-1) and col (0..COLS-1) counters SHALL be kept; cursor SHALL be computed from them without division.
REQ-016 States: IDLE, PUT, SCROLL_COPY, SCROLL_CLEAR, CLEAR_ALL, WAIT; rx_ready SHALL be 1 only in IDLE.
REQ-017 A byte is accepted when rx_valid and rx_ready are both 1; wr_start for it SHALL assert exactly one cycle after acceptance.
REQ-018 wr_start SHALL be high for exactly one cycle per request; wr_begin/wr_end/wr_data/wr_offset SHALL be stable from that cycle until wr_complete is sampled.
REQ-019 WAIT SHALL hold until wr_complete is 1, then proceed to the next step or IDLE on the following cycle; wr_complete outside WAIT SHALL be ignored.
REQ-020 Printable 0x20-0x7E: PUT request begin=cursor, end=cursor+1, data=byte, offset=0; then col+1; on col==COLS-1 col:=0 and row+1.
REQ-021 0x0D: col:=0, no request, return to IDLE next cycle.
REQ-022 0x0A: row+1, col unchanged, no write request.
REQ-023 0x08: if col>0 col-1, else unchanged; no request, no row change.
REQ-024 All other bytes SHALL be consumed and ignored.
REQ-025 When a row increment would reach ROWS, row SHALL remain ROWS-1 and a scroll SHALL run: SCROLL_COPY begin=0, end=(ROWS-1)*COLS, offset=COLS; then SCROLL_CLEAR begin=(ROWS-1)*COLS, end=ROWS*COLS, data=0x20, offset=0.
REQ-026 After a wrapping printable, the scroll SHALL follow the PUT without returning to IDLE.
REQ-027 cursor SHALL update on the cycle the state leaves WAIT (or the command state for non-writing bytes), never while a request is outstanding.
REQ-028 All address arithmetic SHALL be 11-bit unsigned; no request with wr_begin==wr_end SHALL be issued.

Reset
REQ-029 While rst_n is 0 at a clock edge: state:=IDLE, row:=0, col:=0, cursor=0, wr_start=0, wr_begin=0, wr_end=0, wr_data=0, wr_offset=0, rx_ready=0 during that cycle.
REQ-030 Reset mid-request SHALL abandon the request; a later stray wr_complete SHALL have no effect.
REQ-031 rx_ready SHALL be 1 in the first cycle after rst_n returns to 1.

Configuration
REQ-032 Macro TERM_FORMFEED_EN defined: byte 0x0C SHALL issue CLEAR_ALL begin=0, end=ROWS*COLS, data=0x20, offset=0, then row:=0, col:=0.
REQ-033 TERM_FORMFEED_EN undefined: 0x0C SHALL be treated per REQ-024 and CLEAR_ALL logic SHALL not be built.

Verification
REQ-034 Reset, send 'A' (0x41) -> wr_start one cycle after accept, begin=0, end=1, data=0x41, offset=0; after wr_complete cursor=1.
REQ-035 Cursor at 5, send 0x0D then 0x0A -> no wr_start, cursor=0 then 80.
REQ-036 Cursor at 1999, send 'Z' -> PUT begin=1999; then copy begin=0, end=1920, offset=80; then fill begin=1920, end=2000, data=0x20; cursor=1920.
REQ-037 Row 24 col 7, send 0x0A -> scroll pair per REQ-025, cursor=1927; rx_ready low until second wr_complete.
REQ-038 Hold wr_complete low 500 cycles after 'A' -> rx_ready stays 0, outputs stable; assert rst_n=0 mid-wait -> cursor=0, rx_ready 1 after release.
REQ-039 With TERM_FORMFEED_EN, cursor 300, send 0x0C -> begin=0, end=2000, data=0x20, cursor=0; without macro -> no wr_start, cursor=300.
